// File: rtl/bus_err_drain.sv
// Drains the bus error FIFO one record at a time into a software-visible holding register.
// Also keeps a saturating error total and a sticky overflow flag, and raises a coalesced interrupt.
module bus_err_drain #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned ErrBits       = 3,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeoutWidth  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     err_irq_i,
  input  logic [ErrBits-1:0]       err_code_i,
  input  logic [AddrWidth-1:0]     err_addr_i,
  input  logic [MetaDataWidth-1:0] err_meta_i,
  input  logic                     err_fifo_overflow_i,
  output logic                     err_fifo_pop_o,
  output logic                     entry_valid_o,
  output logic [ErrBits-1:0]       entry_code_o,
  output logic [AddrWidth-1:0]     entry_addr_o,
  output logic [MetaDataWidth-1:0] entry_meta_o,
  input  logic                     sw_ack_i,
  input  logic                     clear_i,
  input  logic                     irq_clr_i,
  input  logic [CntWidth-1:0]      coalesce_thresh_i,
  input  logic [TimeoutWidth-1:0]  timeout_i,
  output logic [CntWidth-1:0]      err_count_o,
  output logic                     overflow_o,
  output logic                     irq_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  state_e                   state_q, state_d;
  logic                     pop, capture;
  logic                     valid_q;
  logic [ErrBits-1:0]       code_q;
  logic [AddrWidth-1:0]     addr_q;
  logic [MetaDataWidth-1:0] meta_q;
  logic [CntWidth-1:0]      count_q, pending_q;
  logic [TimeoutWidth-1:0]  timer_q;
  logic                     irq_q, ovf_q;
  logic [CntWidth-1:0]      thresh_eff;
  logic                     irq_set;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    if (clear_i) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (err_irq_i) begin
            pop     = 1'b1;
            capture = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (sw_ack_i) state_d = IDLE;
        end
        FLUSH: begin
          if (err_irq_i) pop = 1'b1;
          else           state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset forces IDLE, where err_irq_i alone would otherwise produce a pop.
  assign err_fifo_pop_o = pop & ~rst_i;

  assign thresh_eff = (coalesce_thresh_i == '0) ? CntOne : coalesce_thresh_i;
  assign irq_set    = (pending_q >= thresh_eff) ||
                      ((timeout_i != '0) && (pending_q != '0) && (timer_q >= timeout_i));

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding register is software-visible, so its fields are reset along with the control state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      addr_q  <= '0;
      meta_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      code_q  <= err_code_i;
      addr_q  <= err_addr_i;
      meta_q  <= err_meta_i;
    end else if ((state_q == HOLD) && sw_ack_i) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (capture && (count_q != CntMax)) begin
      count_q <= count_q + CntOne;
    end
  end

  // An acknowledge that coincides with a capture leaves exactly that new error pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else if (clear_i) begin
      pending_q <= '0;
    end else if (irq_clr_i) begin
      pending_q <= capture ? CntOne : '0;
    end else if (capture && (pending_q != CntMax)) begin
      pending_q <= pending_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else if (clear_i || irq_clr_i || (pending_q == '0) || irq_q) begin
      timer_q <= '0;
    end else if (timer_q < timeout_i) begin
      timer_q <= timer_q + TimeoutWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (clear_i) begin
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (irq_clr_i)    irq_q <= 1'b0;
      else if (irq_set) irq_q <= 1'b1;
      if (err_fifo_overflow_i) ovf_q <= 1'b1;
    end
  end

  assign entry_valid_o = valid_q;
  assign entry_code_o  = code_q;
  assign entry_addr_o  = addr_q;
  assign entry_meta_o  = meta_q;
  assign err_count_o   = count_q;
  assign overflow_o    = ovf_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_bus_err_drain.sv
// Self-checking bench for bus_err_drain: single-cycle vector table plus multi-cycle sequences.
// A second instance with a 4-bit counter exercises saturation.
module tb_bus_err_drain;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        err_irq_i;
  logic [2:0]  err_code_i;
  logic [47:0] err_addr_i;
  logic [0:0]  err_meta_i;
  logic        err_fifo_overflow_i;
  logic        err_fifo_pop_o;
  logic        entry_valid_o;
  logic [2:0]  entry_code_o;
  logic [47:0] entry_addr_o;
  logic [0:0]  entry_meta_o;
  logic        sw_ack_i, clear_i, irq_clr_i;
  logic [15:0] coalesce_thresh_i;
  logic [15:0] timeout_i;
  logic [15:0] err_count_o;
  logic        overflow_o, irq_o;

  // Saturation instance signals
  logic        s_err_irq, s_ack, s_pop, s_valid, s_ovf, s_irq;
  logic [2:0]  s_code;
  logic [47:0] s_addr;
  logic [0:0]  s_meta;
  logic [3:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  bus_err_drain dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .err_irq_i(err_irq_i), .err_code_i(err_code_i), .err_addr_i(err_addr_i),
    .err_meta_i(err_meta_i), .err_fifo_overflow_i(err_fifo_overflow_i),
    .err_fifo_pop_o(err_fifo_pop_o), .entry_valid_o(entry_valid_o),
    .entry_code_o(entry_code_o), .entry_addr_o(entry_addr_o), .entry_meta_o(entry_meta_o),
    .sw_ack_i(sw_ack_i), .clear_i(clear_i), .irq_clr_i(irq_clr_i),
    .coalesce_thresh_i(coalesce_thresh_i), .timeout_i(timeout_i),
    .err_count_o(err_count_o), .overflow_o(overflow_o), .irq_o(irq_o)
  );

  bus_err_drain #(.CntWidth(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .err_irq_i(s_err_irq), .err_code_i(3'd2), .err_addr_i(48'h55),
    .err_meta_i(1'b0), .err_fifo_overflow_i(1'b0),
    .err_fifo_pop_o(s_pop), .entry_valid_o(s_valid),
    .entry_code_o(s_code), .entry_addr_o(s_addr), .entry_meta_o(s_meta),
    .sw_ack_i(s_ack), .clear_i(1'b0), .irq_clr_i(1'b0),
    .coalesce_thresh_i(4'd0), .timeout_i(16'd0),
    .err_count_o(s_count), .overflow_o(s_ovf), .irq_o(s_irq)
  );

  typedef struct {
    logic [2:0]  code;
    logic [47:0] addr;
    logic [0:0]  meta;
  } rec_t;

  typedef struct {
    logic        irq;
    logic [2:0]  code;
    logic [47:0] addr;
    logic        ack, clr, iclr, ovf;
    logic        e_pop, e_valid;
    logic [2:0]  e_code;
    logic [47:0] e_addr;
    logic [15:0] e_cnt;
    logic        e_irq, e_ovf;
  } vec_t;

  rec_t fifo[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle driven from the upstream FIFO model; called at the falling edge.
  task automatic cycle(output logic pop_seen);
    err_irq_i = (fifo.size() != 0);
    if (fifo.size() != 0) begin
      err_code_i = fifo[0].code;
      err_addr_i = fifo[0].addr;
      err_meta_i = fifo[0].meta;
    end
    #1;
    pop_seen = err_fifo_pop_o;
    @(posedge clk_i);
    if (pop_seen && fifo.size() != 0) void'(fifo.pop_front());
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  vec_t vecs[11];
  logic p;
  int   pops, k, hit;
  int   pop_idx[$];

  initial begin
    rst_i = 1'b1;
    err_irq_i = 1'b0; err_code_i = '0; err_addr_i = '0; err_meta_i = '0;
    err_fifo_overflow_i = 1'b0;
    sw_ack_i = 1'b0; clear_i = 1'b0; irq_clr_i = 1'b0;
    coalesce_thresh_i = 16'd3; timeout_i = 16'd0;
    s_err_irq = 1'b0; s_ack = 1'b0;

    // irq, code, addr, ack, clr, iclr, ovf | pop, valid, code, addr, cnt, irq, ovf
    vecs[0]  = '{1'b1, 3'd3, 48'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 48'h1000, 16'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd5, 48'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 48'h1000, 16'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd5, 48'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 48'h1000, 16'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd5, 48'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 48'h2000, 16'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd5, 48'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 48'h2000, 16'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd7, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 48'hFFFF_FFFF_FFFF, 16'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 48'hFFFF_FFFF_FFFF, 16'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 48'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 48'hFFFF_FFFF_FFFF, 16'd3, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 48'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 48'hFFFF_FFFF_FFFF, 16'd3, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3'd1, 48'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 48'h42, 16'd4, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 48'h42, 16'd4, 1'b0, 1'b1};

    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    check("reset pop",   err_fifo_pop_o, 0);
    check("reset valid", entry_valid_o, 0);
    check("reset addr",  entry_addr_o, 0);
    check("reset count", err_count_o, 0);
    check("reset irq",   irq_o, 0);
    check("reset ovf",   overflow_o, 0);

    // Single-cycle vector table, thresh=3, timeout off
    for (int i = 0; i < 11; i++) begin
      err_irq_i = vecs[i].irq; err_code_i = vecs[i].code; err_addr_i = vecs[i].addr;
      sw_ack_i = vecs[i].ack; clear_i = vecs[i].clr; irq_clr_i = vecs[i].iclr;
      err_fifo_overflow_i = vecs[i].ovf;
      #1;
      check($sformatf("v%0d pop", i), err_fifo_pop_o, vecs[i].e_pop);
      @(posedge clk_i);
      @(negedge clk_i);
      sw_ack_i = 1'b0; clear_i = 1'b0; irq_clr_i = 1'b0; err_fifo_overflow_i = 1'b0;
      check($sformatf("v%0d valid", i), entry_valid_o, vecs[i].e_valid);
      check($sformatf("v%0d code", i),  entry_code_o,  vecs[i].e_code);
      check($sformatf("v%0d addr", i),  entry_addr_o,  vecs[i].e_addr);
      check($sformatf("v%0d count", i), err_count_o,   vecs[i].e_cnt);
      check($sformatf("v%0d irq", i),   irq_o,         vecs[i].e_irq);
      check($sformatf("v%0d ovf", i),   overflow_o,    vecs[i].e_ovf);
    end
    err_irq_i = 1'b0;

    // Flush: four queued errors, clear_i taken while in HOLD
    for (int i = 0; i < 4; i++) fifo.push_back('{3'(i), 48'(i + 'h100), 1'b1});
    clear_i = 1'b1;
    cycle(p);
    clear_i = 1'b0;
    check("clear no pop", p, 0);
    check("clear count",  err_count_o, 0);
    check("clear valid",  entry_valid_o, 0);
    check("clear ovf",    overflow_o, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(p);
      check($sformatf("flush pop%0d", i), p, 1);
      check($sformatf("flush count%0d", i), err_count_o, 0);
    end
    check("flush drained", fifo.size(), 0);
    cycle(p);
    check("flush exit no pop", p, 0);
    fifo.push_back('{3'd6, 48'hABC, 1'b1});
    cycle(p);
    check("post-flush pop",   p, 1);
    check("post-flush count", err_count_o, 1);
    check("post-flush meta",  entry_meta_o, 1);

    // Asynchronous reset while in HOLD with another error waiting
    fifo.push_back('{3'd2, 48'h2222, 1'b0});
    err_irq_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    check("async rst valid", entry_valid_o, 0);
    check("async rst count", err_count_o, 0);
    check("async rst pop",   err_fifo_pop_o, 0);
    check("async rst code",  entry_code_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Three queued errors, acked in the first cycle entry_valid_o is seen
    fifo.push_back('{3'd3, 48'h3333, 1'b0});
    fifo.push_back('{3'd4, 48'h4444, 1'b0});
    for (int c = 0; c < 8; c++) begin
      sw_ack_i = entry_valid_o;
      cycle(p);
      if (p) pop_idx.push_back(c);
    end
    sw_ack_i = 1'b0;
    check("3err pops", pop_idx.size(), 3);
    if (pop_idx.size() == 3) begin
      check("3err pop0 cycle", pop_idx[0], 0);
      check("3err pop1 cycle", pop_idx[1], 2);
      check("3err pop2 cycle", pop_idx[2], 4);
    end
    check("3err count", err_count_o, 3);
    check("3err last addr", entry_addr_o, 48'h4444);

    // Timeout: thresh 8, timeout 10, one error
    do_reset();
    coalesce_thresh_i = 16'd8; timeout_i = 16'd10;
    fifo.push_back('{3'd1, 48'h10, 1'b0});
    cycle(p);
    check("tmo pop", p, 1);
    hit = 0;
    for (k = 1; k <= 30; k++) begin
      cycle(p);
      if (irq_o) begin
        hit = k;
        break;
      end
    end
    check("tmo irq latency", hit, 11);

    // irq_clr_i together with a capture leaves one pending: with thresh 1 the irq comes back
    coalesce_thresh_i = 16'd1;
    sw_ack_i = 1'b1;
    cycle(p);
    sw_ack_i = 1'b0;
    fifo.push_back('{3'd5, 48'h50, 1'b0});
    irq_clr_i = 1'b1;
    cycle(p);
    irq_clr_i = 1'b0;
    check("clr+cap pop", p, 1);
    check("clr+cap irq low", irq_o, 0);
    cycle(p);
    check("clr+cap irq re-set", irq_o, 1);

    // Saturation on the 4-bit instance: 20 captures
    do_reset();
    pops = 0;
    s_err_irq = 1'b1; s_ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (s_pop) pops++;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    s_err_irq = 1'b0; s_ack = 1'b0;
    check("sat pops",  pops, 20);
    check("sat count", s_count, 15);
    check("sat irq",   s_irq, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
